coin_input_conditioner: RTL and testbench
=========================================

# coin_input_conditioner

Front-end stage that sits directly upstream of `vending_machine` and drives its `a`, `b`, `c` coin inputs. It synchronises and debounces three raw coin-sensor lines and converts each clean coin insertion into exactly one single-cycle pulse. It arbitrates simultaneous insertions and enforces a post-coin lockout window. Any coin that cannot be credited is flagged on `reject` so the coin-return path can act.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised samples required before a level change is accepted (≥1).
- `LOCKOUT_CYCLES`, 8: cycles after an accepted coin during which new coins are rejected (0 = no lockout).

Ports:
- `clk`  input  1  single system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `raw_a`, `raw_b`, `raw_c`  input  1 each  asynchronous, bouncy coin-sensor lines (high = coin present).
- `a`, `b`, `c`  output  1 each  one-cycle coin pulses to `vending_machine`.
- `reject`  output  1  one-cycle pulse: a detected coin was not credited.
- `busy`  output  1  high while the lockout window is active.
- `accepted_cnt`  output  8  running count of credited coins.

## Operation
- Synchroniser: each raw line passes through 2 flops (`s1`, `s2`).
- Debounce, per channel:
  - Each channel keeps a `stable` bit and a counter.
  - While `s2 != stable`, the counter increments. When it would reach `DEBOUNCE_CYCLES`, `stable` takes the value of `s2` and the counter clears.
  - Any sample with `s2 == stable` clears the counter.
- Event: a 0→1 transition of `stable` creates a candidate event for that channel. 1→0 transitions do nothing.
- Arbiter/lockout FSM:
  - States: IDLE (`lock_cnt` = 0) and LOCKOUT (`lock_cnt` ≠ 0).
  - IDLE with ≥1 candidate:
    - Credit the highest priority, `c` > `b` > `a`.
    - Pulse the matching output next cycle.
    - Increment `accepted_cnt`; it wraps 255→0.
    - Load `lock_cnt` = `LOCKOUT_CYCLES`.
    - Every other simultaneous candidate is dropped and `reject` pulses in the same cycle as the credited pulse.
  - LOCKOUT: `lock_cnt` decrements every cycle. Any candidate arriving here is dropped with a `reject` pulse and does not reload or extend the counter.
  - With `LOCKOUT_CYCLES` = 0 the FSM never leaves IDLE, so coins on consecutive cycles are all credited.
- `busy` = (`lock_cnt` ≠ 0), registered.
- At most one of `a`/`b`/`c` is high in any cycle. `reject` may coincide with one of them.

## Timing
- Reset values: `a`, `b`, `c`, `reject`, `busy` = 0 and `accepted_cnt` = 0. All sync flops, `stable` bits, debounce counters and `lock_cnt` also reset to 0.
- Latency, with D = `DEBOUNCE_CYCLES`: if `raw_x` is high at rising edge k and stays high, `stable` rises at edge k+D+1. The output pulse is high from edge k+D+2 to k+D+3. With D=4, that is high for one cycle starting at edge k+6.
- Glitches: a high or low glitch shorter than D sampled cycles at `s2` produces no event.
- Lockout window: for a coin credited with its pulse asserted at edge E:
  - Candidates evaluated at edges E+1 … E+L are rejected, where L = `LOCKOUT_CYCLES`.
  - A candidate evaluated at edge E+L+1 is credited.
  - `busy` is high from edge E through edge E+L.
- Sensor held high: one coin only, until the line drops low for D cycles and rises again.
- Line high across reset: it is counted once after reset releases, with normal latency measured from the first non-reset edge.
- Reset mid-operation: it takes effect at the next edge, which clears pending events, lockout and pulses. No output pulses in the cycle after a reset edge.

## Test plan
- Clean single coin: `raw_b` high for 10 cycles at edge 5, D=4 → `b` pulses exactly once at edge 11, `accepted_cnt` 0→1, `busy` high for edges 11–19 with L=8, no `reject`.
- Bounce: `raw_a` toggles every 2 cycles for 12 cycles, then held high → one `a` pulse exactly 6 edges after the last rise; no pulse during bouncing.
- Simultaneous: `raw_a`, `raw_b`, `raw_c` all rise at the same edge → only `c` pulses; `reject` pulses in the same cycle; `accepted_cnt` +1.
- Lockout boundary: credit `a` at edge E; arrange a `b` candidate at E+8 → `reject`, no `b`; arrange another at E+9 → `b` credited. With L=0, back-to-back coins are both credited.
- Reset: assert `reset` one edge before an expected pulse → no pulse, all outputs 0; 256 credited coins → `accepted_cnt` wraps to 0.

Source files
------------

// File: rtl/coin_input_conditioner.sv
// -----------------------------------------------------------------------------
// coin_input_conditioner
//
// Front end for vending_machine. Synchronises and debounces three raw coin
// sensor lines, turns every clean insertion into one single-cycle pulse on
// a/b/c, arbitrates simultaneous insertions (c > b > a) and enforces a
// lockout window after each credited coin. Coins that are detected but not
// credited are flagged on reject so the coin-return path can act.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive synchronised samples needed to accept a
//                    level change (>= 1)
//   LOCKOUT_CYCLES   cycles after a credit during which new coins are
//                    rejected (0 = no lockout)
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   raw_a/b/c     asynchronous, bouncy coin sensor lines (high = coin)
//   a/b/c         one-cycle coin pulses to vending_machine
//   reject        one-cycle pulse, a detected coin was not credited
//   busy          high while the lockout window is active
//   accepted_cnt  running count of credited coins, wraps 255 -> 0
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// coin_debounce
//
// One sensor channel: two-flop synchroniser, then a debounce filter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
// rise is a registered one-cycle flag marking a 0->1 change of the filtered
// level; falling changes produce nothing.
//
// Ports
//   clk, reset  as in the top level
//   raw         asynchronous sensor line
//   rise        one-cycle flag, filtered level just went high
// -----------------------------------------------------------------------------
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic rise
);

   // The counter only ever needs to hold DEBOUNCE_CYCLES-1; reaching the
   // last value on a differing sample is what commits the new level.
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   logic           s1;
   logic           s2;
   logic           stable;
   logic [DBW-1:0] db_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         stable <= 1'b0;
         db_cnt <= '0;
         rise   <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= 1'b0;
         if (s2 != stable) begin
            if (db_cnt == DB_LAST) begin
               stable <= s2;
               db_cnt <= '0;
               rise   <= s2;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            // any agreeing sample restarts the count, so glitches shorter
            // than the window never commit
            db_cnt <= '0;
         end
      end
   end

endmodule

// -----------------------------------------------------------------------------
// Arbiter / lockout FSM
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   IDLE    | lock_cnt == 0; the first candidate(s) seen are arbitrated and
//           | the winner credited, the rest rejected
//   LOCKOUT | lock_cnt != 0; counts down every cycle, every candidate is
//           | rejected and the window is never extended
// -----------------------------------------------------------------------------
module coin_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       raw_a,
   input  logic       raw_b,
   input  logic       raw_c,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       reject,
   output logic       busy,
   output logic [7:0] accepted_cnt
);

   localparam int LKW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
   localparam logic [LKW-1:0] LOCK_LOAD = LKW'(LOCKOUT_CYCLES);
   localparam logic [LKW-1:0] LOCK_LAST = LKW'(1);
   localparam logic           HAS_LOCK  = (LOCKOUT_CYCLES != 0);

   typedef enum logic {
      IDLE    = 1'b0,
      LOCKOUT = 1'b1
   } state_t;

   // bit 2 = c, bit 1 = b, bit 0 = a throughout
   logic [2:0]     cand;
   logic [2:0]     grant_d;
   logic           reject_d;
   logic           credit;
   logic           busy_d;
   state_t         state_q;
   state_t         state_d;
   logic [LKW-1:0] lock_cnt;
   logic [LKW-1:0] lock_d;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_a),
      .rise  (cand[0])
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_b),
      .rise  (cand[1])
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_c),
      .rise  (cand[2])
   );

   // state register, plus the registered pulse outputs and credit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         lock_cnt     <= '0;
         a            <= 1'b0;
         b            <= 1'b0;
         c            <= 1'b0;
         reject       <= 1'b0;
         busy         <= 1'b0;
         accepted_cnt <= 8'd0;
      end else begin
         state_q  <= state_d;
         lock_cnt <= lock_d;
         a        <= grant_d[0];
         b        <= grant_d[1];
         c        <= grant_d[2];
         reject   <= reject_d;
         busy     <= busy_d;
         if (credit) begin
            accepted_cnt <= accepted_cnt + 8'd1;
         end
      end
   end

   // next state and lockout timer
   always_comb begin
      state_d = state_q;
      lock_d  = lock_cnt;
      case (state_q)
         IDLE: begin
            // with no lockout configured the FSM stays here, so coins on
            // consecutive cycles are all credited
            if ((|cand) && HAS_LOCK) begin
               state_d = LOCKOUT;
               lock_d  = LOCK_LOAD;
            end
         end
         LOCKOUT: begin
            lock_d = lock_cnt - 1'b1;
            if (lock_cnt == LOCK_LAST) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            lock_d  = '0;
         end
      endcase
   end

   // outputs: arbitration, reject and busy
   always_comb begin
      grant_d  = 3'b000;
      reject_d = 1'b0;
      credit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cand[2]) begin
               grant_d = 3'b100;
            end else if (cand[1]) begin
               grant_d = 3'b010;
            end else if (cand[0]) begin
               grant_d = 3'b001;
            end
            credit   = |cand;
            reject_d = |(cand & ~grant_d);
         end
         LOCKOUT: begin
            reject_d = |cand;
         end
         default: begin
            grant_d  = 3'b000;
         end
      endcase
      // covers the credit cycle itself (entering LOCKOUT) through the cycle
      // in which the timer reaches zero (leaving LOCKOUT)
      busy_d = (state_q == LOCKOUT) || (state_d == LOCKOUT);
   end

endmodule

// File: tb/tb_coin_input_conditioner.sv
module tb_coin_input_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       raw_a, raw_b, raw_c;
   logic       a, b, c, reject, busy;
   logic [7:0] accepted_cnt;
   logic       a0, b0, c0, reject0, busy0;
   logic [7:0] accepted_cnt0;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_cnt  = 8'd0;
   logic [7:0] exp_cnt0 = 8'd0;

   always #5 clk = ~clk;

   coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .raw_a        (raw_a),
      .raw_b        (raw_b),
      .raw_c        (raw_c),
      .a            (a),
      .b            (b),
      .c            (c),
      .reject       (reject),
      .busy         (busy),
      .accepted_cnt (accepted_cnt)
   );

   coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(0)) dut0 (
      .clk          (clk),
      .reset        (reset),
      .raw_a        (raw_a),
      .raw_b        (raw_b),
      .raw_c        (raw_c),
      .a            (a0),
      .b            (b0),
      .c            (c0),
      .reject       (reject0),
      .busy         (busy0),
      .accepted_cnt (accepted_cnt0)
   );

   // advance one rising edge and sample 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      logic [4:0] exp;
      reset = 1'b1;
      raw_a = 1'b0;
      raw_b = 1'b0;
      raw_c = 1'b0;
      idle(3);
      exp = 5'b00000;
      n_checks++;
      if ({a, b, c, reject, busy} !== exp) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected %b", {a, b, c, reject, busy}, exp);
      end
      n_checks++;
      if (accepted_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %0d expected 0", accepted_cnt);
      end
      n_checks++;
      if ({a0, b0, c0, reject0, busy0, accepted_cnt0} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_dut0: got %b expected all zero", {a0, b0, c0, reject0, busy0, accepted_cnt0});
      end
      reset = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         n_checks++;
         if ({a, b, c, reject, busy} !== exp) begin
            n_fail++;
            $display("FAIL post_reset_quiet tick %0d: got %b expected %b", i, {a, b, c, reject, busy}, exp);
         end
      end
   endtask

   task automatic test_clean_coin();
      logic [4:0] exp;
      raw_b = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         exp = {1'b0, (i == 7), 1'b0, 1'b0, (i >= 7 && i <= 15)};
         n_checks++;
         if ({a, b, c, reject, busy} !== exp) begin
            n_fail++;
            $display("FAIL clean_coin tick %0d: got abc_rej_busy=%b expected %b", i, {a, b, c, reject, busy}, exp);
         end
         if (i == 6 || i == 7) begin
            n_checks++;
            if (accepted_cnt !== ((i == 7) ? 8'd1 : 8'd0)) begin
               n_fail++;
               $display("FAIL clean_coin_cnt tick %0d: got %0d expected %0d", i, accepted_cnt, (i == 7) ? 1 : 0);
            end
         end
         if (i == 10) raw_b = 1'b0;
      end
      exp_cnt  = exp_cnt + 8'd1;
      exp_cnt0 = exp_cnt0 + 8'd1;
      idle(10);
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 12; i++) begin
         raw_a = ((i / 2) % 2 == 0);
         tick();
         n_checks++;
         if ({a, b, c, reject} !== 4'b0000) begin
            n_fail++;
            $display("FAIL bounce_quiet step %0d: got %b expected 0000", i, {a, b, c, reject});
         end
      end
      raw_a = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         tick();
         n_checks++;
         if ({a, reject} !== {(j == 7), 1'b0}) begin
            n_fail++;
            $display("FAIL bounce_pulse tick %0d: got a,rej=%b expected %b", j, {a, reject}, {(j == 7), 1'b0});
         end
      end
      exp_cnt  = exp_cnt + 8'd1;
      exp_cnt0 = exp_cnt0 + 8'd1;
      n_checks++;
      if (accepted_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL bounce_cnt: got %0d expected %0d", accepted_cnt, exp_cnt);
      end
      // sensor held high must not produce a second coin
      for (int j = 0; j < 20; j++) begin
         tick();
         n_checks++;
         if (a !== 1'b0) begin
            n_fail++;
            $display("FAIL held_high tick %0d: got a=%b expected 0", j, a);
         end
      end
      raw_a = 1'b0;
      idle(10);
   endtask

   task automatic test_simultaneous();
      logic [4:0] exp;
      raw_a = 1'b1;
      raw_b = 1'b1;
      raw_c = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         tick();
         exp = {1'b0, 1'b0, (j == 7), (j == 7), (j >= 7)};
         n_checks++;
         if ({a, b, c, reject, busy} !== exp) begin
            n_fail++;
            $display("FAIL simultaneous tick %0d: got abc_rej_busy=%b expected %b", j, {a, b, c, reject, busy}, exp);
         end
      end
      exp_cnt  = exp_cnt + 8'd1;
      exp_cnt0 = exp_cnt0 + 8'd1;
      n_checks++;
      if (accepted_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL simultaneous_cnt: got %0d expected %0d", accepted_cnt, exp_cnt);
      end
      raw_a = 1'b0;
      raw_b = 1'b0;
      raw_c = 1'b0;
      idle(20);
   endtask

   // a credited at tick 7 (edge E); b raised after tick 8 makes its candidate
   // land on E+8 (rejected), after tick 9 on E+9 (credited)
   task automatic test_lockout_boundary();
      logic [4:0] exp;
      for (int r = 0; r < 2; r++) begin
         raw_a = 1'b1;
         for (int i = 1; i <= 17; i++) begin
            tick();
            if (r == 0)
               exp = {(i == 7), 1'b0, 1'b0, (i == 15), (i >= 7 && i <= 15)};
            else
               exp = {(i == 7), (i == 16), 1'b0, 1'b0, (i >= 7)};
            n_checks++;
            if ({a, b, c, reject, busy} !== exp) begin
               n_fail++;
               $display("FAIL lockout_run%0d tick %0d: got abc_rej_busy=%b expected %b", r, i, {a, b, c, reject, busy}, exp);
            end
            if (i == 8 + r) raw_b = 1'b1;
         end
         exp_cnt  = exp_cnt + ((r == 0) ? 8'd1 : 8'd2);
         exp_cnt0 = exp_cnt0 + 8'd2;
         n_checks++;
         if (accepted_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL lockout_cnt run%0d: got %0d expected %0d", r, accepted_cnt, exp_cnt);
         end
         raw_a = 1'b0;
         raw_b = 1'b0;
         idle(25);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp;
      logic [4:0] exp0;
      raw_a = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         exp0 = {(i == 7), (i == 8), 1'b0, 1'b0, 1'b0};
         exp  = {(i == 7), 1'b0, 1'b0, (i == 8), (i >= 7)};
         n_checks++;
         if ({a0, b0, c0, reject0, busy0} !== exp0) begin
            n_fail++;
            $display("FAIL back_to_back_l0 tick %0d: got %b expected %b", i, {a0, b0, c0, reject0, busy0}, exp0);
         end
         n_checks++;
         if ({a, b, c, reject, busy} !== exp) begin
            n_fail++;
            $display("FAIL back_to_back_l8 tick %0d: got %b expected %b", i, {a, b, c, reject, busy}, exp);
         end
         if (i == 1) raw_b = 1'b1;
      end
      exp_cnt0 = exp_cnt0 + 8'd2;
      exp_cnt  = exp_cnt + 8'd1;
      n_checks++;
      if (accepted_cnt0 !== exp_cnt0) begin
         n_fail++;
         $display("FAIL back_to_back_cnt0: got %0d expected %0d", accepted_cnt0, exp_cnt0);
      end
      n_checks++;
      if (accepted_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL back_to_back_cnt: got %0d expected %0d", accepted_cnt, exp_cnt);
      end
      raw_a = 1'b0;
      raw_b = 1'b0;
      idle(20);
   endtask

   // c would pulse at tick 7; reset sampled at edge 6 kills it, and the line
   // still high is then counted once from edge 7 (pulse at tick 13)
   task automatic test_reset_midop();
      raw_c = 1'b1;
      idle(5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({a, b, c, reject, busy, accepted_cnt} !== 13'd0) begin
         n_fail++;
         $display("FAIL midop_reset_outputs: got %b expected all zero", {a, b, c, reject, busy, accepted_cnt});
      end
      n_checks++;
      if ({a0, b0, c0, reject0, busy0, accepted_cnt0} !== 13'd0) begin
         n_fail++;
         $display("FAIL midop_reset_dut0: got %b expected all zero", {a0, b0, c0, reject0, busy0, accepted_cnt0});
      end
      exp_cnt  = 8'd0;
      exp_cnt0 = 8'd0;
      for (int i = 7; i <= 14; i++) begin
         tick();
         n_checks++;
         if ({a, b, c, reject} !== {1'b0, 1'b0, (i == 13), 1'b0}) begin
            n_fail++;
            $display("FAIL midop_relatch tick %0d: got %b expected %b", i, {a, b, c, reject}, {1'b0, 1'b0, (i == 13), 1'b0});
         end
         n_checks++;
         if (c0 !== (i == 13)) begin
            n_fail++;
            $display("FAIL midop_relatch_dut0 tick %0d: got %b expected %b", i, c0, (i == 13));
         end
      end
      exp_cnt  = 8'd1;
      exp_cnt0 = 8'd1;
      n_checks++;
      if (accepted_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL midop_cnt: got %0d expected %0d", accepted_cnt, exp_cnt);
      end
      raw_c = 1'b0;
      idle(20);
   endtask

   task automatic test_wrap();
      for (int n = 0; n < 255; n++) begin
         raw_a = 1'b1;
         idle(8);
         raw_a = 1'b0;
         idle(8);
         exp_cnt  = exp_cnt + 8'd1;
         exp_cnt0 = exp_cnt0 + 8'd1;
         if (n == 253) begin
            n_checks++;
            if (accepted_cnt !== exp_cnt) begin
               n_fail++;
               $display("FAIL wrap_pre: got %0d expected %0d", accepted_cnt, exp_cnt);
            end
         end
      end
      n_checks++;
      if (accepted_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL wrap: got %0d expected %0d", accepted_cnt, exp_cnt);
      end
      n_checks++;
      if (accepted_cnt0 !== exp_cnt0) begin
         n_fail++;
         $display("FAIL wrap_dut0: got %0d expected %0d", accepted_cnt0, exp_cnt0);
      end
   endtask

   initial begin
      reset = 1'b1;
      raw_a = 1'b0;
      raw_b = 1'b0;
      raw_c = 1'b0;
      test_reset();
      test_clean_coin();
      test_bounce();
      test_simultaneous();
      test_lockout_boundary();
      test_back_to_back();
      test_reset_midop();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
